// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU command sequencer.
// Optional accumulate mode is selected by the ALU_SEQ_ACC_EN macro in the top file.
package alu_seq_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = 4;
    localparam int OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        S_OP     = 3'd0,
        S_A      = 3'd1,
        S_B      = 3'd2,
        S_EXEC   = 3'd3,
        S_RESULT = 3'd4
    } seq_state_e;

    function automatic logic is_beat_state(seq_state_e s);
        return (s == S_OP) || (s == S_A) || (s == S_B);
    endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Inter-beat idle counter: expire_o fires on the idle cycle that would make the
// count reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 removes the counter entirely.
module alu_seq_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clr_i, en_i};
            assign expire_o      = 1'b0;
        end else begin : g_on
            localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Clear has priority so the parent can restart the count on the expiring cycle.
            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expire_o = en_i && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Serial-beat command front end for the 3-bit ALU: opcode, A, B beats in; result out
// via valid/ready. Define ALU_SEQ_ACC_EN to enable accumulate (opcode din[2] reuses last result as A).
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPND_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_z,
    output logic [RES_W-1:0]  res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              err
);

    seq_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [OPND_W-1:0] a_q, a_d;
    logic [OPND_W-1:0] b_q, b_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              err_q, err_d;

    logic beat;
    logic waiting;
    logic expire;

    assign din_ready = is_beat_state(state_q);
    assign beat      = din_valid && din_ready;
    assign waiting   = (state_q == S_A) || (state_q == S_B);

    // Counter runs only while waiting for an operand; any beat or abort restarts it.
    alu_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (!waiting || beat || expire),
        .en_i    (waiting && !beat),
        .expire_o(expire)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = 1'b0;
        case (state_q)
            S_OP: begin
                if (beat) begin
                    op_d    = din[OP_W-1:0];
                    state_d = S_A;
`ifdef ALU_SEQ_ACC_EN
                    if (din[2]) begin
                        a_d     = res_q[OPND_W-1:0];
                        state_d = S_B;
                    end
`endif
                end
            end
            S_A: begin
                if (beat) begin
                    a_d     = din;
                    state_d = S_B;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = S_OP;
                end
            end
            S_B: begin
                if (beat) begin
                    b_d     = din;
                    state_d = S_EXEC;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = S_OP;
                end
            end
            S_EXEC: begin
                res_d   = alu_z;
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OP;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res       = res_q;
    assign res_valid = (state_q == S_RESULT);
    assign err       = err_q;

endmodule
